// File: rtl/fir_pkg.sv
// Shared types, sizes and coefficient selection for the mod-256 FIR deconvolver.
package fir_pkg;

   typedef logic [7:0] sample_t;

   localparam int unsigned NUM_TAPS = 7;
   localparam int unsigned HIST_LEN = 6;

   typedef enum logic [1:0] {StIdle, StMac, StOut} deconv_state_t;

   // Taps 1..6 of the symmetric set {1, C1, C2, C3, C2, C1, 1}; tap 0 is never multiplied.
   function automatic sample_t coef_sel(input logic [2:0] k, input sample_t c1,
                                        input sample_t c2, input sample_t c3);
      sample_t c;
      case (k)
         3'd1:    c = c1;
         3'd2:    c = c2;
         3'd3:    c = c3;
         3'd4:    c = c2;
         3'd5:    c = c1;
         3'd6:    c = 8'd1;
         default: c = 8'd0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fir_hist_sr.sv
// History of recovered samples: 6-deep shift register with clear and an indexed read port.
module fir_hist_sr
   import fir_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       shift_i,
   input  logic       clr_i,
   input  sample_t    din_i,
   input  logic [2:0] rd_idx_i,
   output sample_t    rd_data_o
);

   sample_t hist_q [HIST_LEN];
   sample_t hist_d [HIST_LEN];

   // Clear and shift together keep the freshly shifted-in sample but drop the rest.
   always_comb begin
      hist_d = hist_q;
      if (clr_i) begin
         for (int i = 0; i < HIST_LEN; i++) hist_d[i] = '0;
      end
      if (shift_i) begin
         for (int i = 1; i < HIST_LEN; i++) hist_d[i] = clr_i ? '0 : hist_q[i-1];
         hist_d[0] = din_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < HIST_LEN; i++) hist_q[i] <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign rd_data_o = (rd_idx_i < 3'(HIST_LEN)) ? hist_q[rd_idx_i] : '0;

endmodule

// File: rtl/fir_deconv.sv
// Inverse of the 7-tap symmetric FIR: one sample in, six serial MAC steps, one sample out.
module fir_deconv
   import fir_pkg::*;
#(
   parameter sample_t C1 = 8'd2,
   parameter sample_t C2 = 8'd3,
   parameter sample_t C3 = 8'd4
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    clr_i,
   input  logic    in_valid_i,
   output logic    in_ready_o,
   input  sample_t in_data_i,
   output logic    out_valid_o,
   input  logic    out_ready_i,
   output sample_t out_data_o
);

   localparam logic [2:0] LastTap = 3'(HIST_LEN);

   deconv_state_t state_q, state_d;
   sample_t       acc_q, acc_d;
   logic [2:0]    k_q, k_d;

   sample_t     hist_rd;
   sample_t     tap;
   logic [15:0] full_prod;
   sample_t     prod;
   logic        hist_shift;

   assign hist_shift = (state_q == StOut) && out_ready_i;

   fir_hist_sr u_hist (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .shift_i  (hist_shift),
      .clr_i    (clr_i),
      .din_i    (acc_q),
      .rd_idx_i (k_q - 3'd1),
      .rd_data_o(hist_rd)
   );

   // A clear during MAC already applies to the step taken in the same cycle.
   assign tap       = clr_i ? '0 : hist_rd;
   assign full_prod = coef_sel(k_q, C1, C2, C3) * tap;
   assign prod      = full_prod[7:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid_i && in_ready_o) state_d = StMac;
         StMac:   if (k_q == LastTap) state_d = StOut;
         StOut:   if (out_ready_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready_o  = (state_q == StIdle) && !rst_i;
      out_valid_o = (state_q == StOut);
      out_data_o  = acc_q;
   end

   always_comb begin
      acc_d = acc_q;
      k_d   = k_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid_i && in_ready_o) begin
               acc_d = in_data_i;
               k_d   = 3'd1;
            end
         end
         StMac: begin
            acc_d = acc_q - prod;
            k_d   = (k_q == LastTap) ? 3'd0 : k_q + 3'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
         k_q   <= '0;
      end else begin
         acc_q <= acc_d;
         k_q   <= k_d;
      end
   end

endmodule
